// File: rtl/ahb_svt_mem_slave.sv
// ahb_svt_mem_slave
//
// Terminating AHB slave memory model for basic-system benches. Sits directly
// behind the interconnect and answers every selected transfer from an internal
// byte-addressable RAM. It inserts WAIT_STATES hready-low cycles before each
// OKAY completion. Illegal accesses get the two-cycle ERROR response.
//
// A transfer is illegal when any of these hold:
//   - the address is outside the RAM;
//   - the transfer is wider than the data bus;
//   - the address is not aligned to the transfer size.
//
// Ports:
//   hclk, hresetn    clock, asynchronous active-low reset
//   hsel             slave select
//   haddr            transfer address
//   htrans           IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//   hwrite           1 = write
//   hsize            transfer size (bytes = 2**hsize)
//   hburst, hprot    accepted but ignored; bursts are served as independent beats
//   hwdata           write data, sampled on the edge that ends the data phase
//   hrdata_s1        read data; full aligned word in the completing cycle of a read, else 0
//   hresp_s1         OKAY=00 or ERROR=01 (RETRY/SPLIT are never used)
//   hready_s1        transfer-done / ready for a new address phase
//   hsplit_s1        always 0
//
// Memory contents survive reset. A write still in flight when reset arrives is
// dropped.

module ahb_svt_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_BYTES   = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned NUM_MASTERS = 16
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   hsel,
    input  logic [ADDR_WIDTH-1:0]  haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [3:0]             hprot,
    input  logic [DATA_WIDTH-1:0]  hwdata,
    output logic [DATA_WIDTH-1:0]  hrdata_s1,
    output logic [1:0]             hresp_s1,
    output logic                   hready_s1,
    output logic [NUM_MASTERS-1:0] hsplit_s1
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_W     = $clog2(BYTES);
    localparam int unsigned MEM_WORDS = MEM_BYTES / BYTES;
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned WAIT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    // One extra bit so that a RAM filling the whole address space still compares correctly.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

    localparam logic [1:0] RespOkay  = 2'b00;
    localparam logic [1:0] RespError = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StLast,
        StErr1,
        StErr2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        size_q;
    logic              write_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic              accept;
    logic              addr_oob;
    logic              size_bad;
    logic              misaligned;
    logic              illegal;
    logic [7:0]        align_mask;
    logic [IDX_W-1:0]  haddr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [BYTES-1:0]  byte_en;
    logic              commit;
    logic [DATA_WIDTH-1:0] rd_word;

    // hburst, hprot and htrans[0] carry nothing this slave acts on.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, htrans[0]};

    assign hsplit_s1 = '0;

    // An address phase only exists while hready_s1 is high (IDLE, LAST, ERR2).
    assign accept    = hsel && hready_s1 && htrans[1];
    assign haddr_idx = haddr[OFF_W +: IDX_W];

    always_comb begin
        addr_oob   = {1'b0, haddr} >= MEM_LIMIT;
        size_bad   = 32'(hsize) > OFF_W;
        align_mask = (8'd1 << hsize) - 8'd1;
        misaligned = (haddr[7:0] & align_mask) != 8'd0;
        illegal    = addr_oob | size_bad | misaligned;
    end

    // Little-endian byte lanes of the registered data-phase transfer.
    always_comb begin
        int unsigned lane_off;
        int unsigned nbytes;
        lane_off = 32'(off_q);
        nbytes   = 32'd1 << size_q;
        byte_en  = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            byte_en[i] = (i >= lane_off) && (i < lane_off + nbytes);
        end
    end

    // The write lands on the edge that ends its LAST cycle.
    assign commit = (state_q == StLast) && write_q;

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (byte_en[i]) begin
                    mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Word loaded into hrdata_s1 on entry to LAST. A write committing on that
    // same edge to the same word is merged in, so a back-to-back read sees it.
    always_comb begin
        rd_idx  = (state_q == StWait) ? idx_q : haddr_idx;
        rd_word = mem[rd_idx];
        if (commit && (idx_q == rd_idx)) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (byte_en[i]) begin
                    rd_word[8*i +: 8] = hwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            hready_s1 <= 1'b1;
            hresp_s1  <= RespOkay;
            hrdata_s1 <= '0;
        end else begin
            hrdata_s1 <= '0;
            unique case (state_q)
                StIdle, StLast, StErr2: begin
                    if (accept) begin
                        idx_q   <= haddr_idx;
                        off_q   <= haddr[OFF_W-1:0];
                        size_q  <= hsize;
                        write_q <= hwrite;
                        if (illegal) begin
                            state_q   <= StErr1;
                            hready_s1 <= 1'b0;
                            hresp_s1  <= RespError;
                        end else if (WAIT_STATES == 0) begin
                            state_q   <= StLast;
                            hready_s1 <= 1'b1;
                            hresp_s1  <= RespOkay;
                            if (!hwrite) begin
                                hrdata_s1 <= rd_word;
                            end
                        end else begin
                            state_q   <= StWait;
                            cnt_q     <= CNT_W'(WAIT_INIT);
                            hready_s1 <= 1'b0;
                            hresp_s1  <= RespOkay;
                        end
                    end else begin
                        state_q   <= StIdle;
                        hready_s1 <= 1'b1;
                        hresp_s1  <= RespOkay;
                    end
                end
                StWait: begin
                    hresp_s1 <= RespOkay;
                    if (cnt_q == '0) begin
                        state_q   <= StLast;
                        hready_s1 <= 1'b1;
                        if (!write_q) begin
                            hrdata_s1 <= rd_word;
                        end
                    end else begin
                        cnt_q     <= cnt_q - 1'b1;
                        hready_s1 <= 1'b0;
                    end
                end
                StErr1: begin
                    state_q   <= StErr2;
                    hready_s1 <= 1'b1;
                    hresp_s1  <= RespError;
                end
                default: begin
                    state_q   <= StIdle;
                    hready_s1 <= 1'b1;
                    hresp_s1  <= RespOkay;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_svt_mem_slave.sv
// Bench for ahb_svt_mem_slave.
//
// Two instances are used: one with zero wait states and one with three. They
// share every input except hsel. Transfers are queued as requests. When the
// address phase is driven, the expected completion is derived from a byte-level
// memory model and pushed to a scoreboard. It is popped and compared when the
// data phase of the selected instance completes.

module tb_ahb_svt_mem_slave;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 4096;
    localparam int unsigned NM = 16;

    logic          hclk = 1'b0;
    logic          hresetn;
    logic          hsel0;
    logic          hsel3;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [DW-1:0] hwdata;

    logic [DW-1:0] rdata0, rdata3;
    logic [1:0]    resp0, resp3;
    logic          rdy0, rdy3;
    logic [NM-1:0] split0, split3;

    always #5 hclk = ~hclk;

    ahb_svt_mem_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_BYTES  (MB),
        .WAIT_STATES(0),
        .NUM_MASTERS(NM)
    ) u_dut_ws0 (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hsel     (hsel0),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hrdata_s1(rdata0),
        .hresp_s1 (resp0),
        .hready_s1(rdy0),
        .hsplit_s1(split0)
    );

    ahb_svt_mem_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_BYTES  (MB),
        .WAIT_STATES(3),
        .NUM_MASTERS(NM)
    ) u_dut_ws3 (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .hsel     (hsel3),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hprot    (hprot),
        .hwdata   (hwdata),
        .hrdata_s1(rdata3),
        .hresp_s1 (resp3),
        .hready_s1(rdy3),
        .hsplit_s1(split3)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [1:0]  resp;
        int          waits;
        logic [31:0] rdata;
        bit          chk_data;
    } exp_t;

    req_t        req_q[$];
    exp_t        exp_q[$];
    logic [7:0]  model [int unsigned];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          sel      = 0;   // 0 -> u_dut_ws0, 1 -> u_dut_ws3
    bit          addr_drv = 1'b0;
    bit          dp_act   = 1'b0;
    int          dp_waits = 0;
    logic [31:0] dp_wdata_next = '0;

    logic        cur_rdy;
    logic [1:0]  cur_resp;
    logic [31:0] cur_rdata;

    always_comb begin
        cur_rdy   = (sel != 0) ? rdy3   : rdy0;
        cur_resp  = (sel != 0) ? resp3  : resp0;
        cur_rdata = (sel != 0) ? rdata3 : rdata0;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic queue_xfer(input bit write, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata);
        req_t r;
        r.write = write;
        r.addr  = addr;
        r.size  = size;
        r.wdata = wdata;
        req_q.push_back(r);
    endtask

    // Expected completion of a request, and its effect on the model memory.
    task automatic push_expected(input req_t r);
        exp_t        e;
        bit          illegal;
        int unsigned nb;
        int unsigned key;
        int unsigned base;
        int unsigned lane;
        nb      = 32'd1 << r.size;
        illegal = (r.addr >= MB) || (nb > DW / 8) || ((r.addr % nb) != 0);
        key     = 32'(sel) * 32'h10000;
        e.resp     = illegal ? 2'b01 : 2'b00;
        e.waits    = illegal ? 1 : ((sel != 0) ? 3 : 0);
        e.chk_data = illegal || !r.write;
        e.rdata    = '0;
        if (!illegal) begin
            base = r.addr - (r.addr % 4);
            if (r.write) begin
                for (int unsigned i = 0; i < nb; i++) begin
                    lane = (r.addr % 4) + i;
                    model[key + r.addr + i] = r.wdata[8*lane +: 8];
                end
            end else begin
                for (int unsigned b = 0; b < 4; b++) begin
                    e.rdata[8*b +: 8] = model.exists(key + base + b) ? model[key + base + b] : 8'h00;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // One bus cycle: advance past the edge, check the data phase, drive the next address.
    task automatic step();
        req_t r;
        exp_t e;
        @(posedge hclk);
        #1;
        if (addr_drv) begin
            // Address was only driven while hready was high, so the edge accepted it.
            addr_drv = 1'b0;
            dp_act   = 1'b1;
            dp_waits = 0;
            hwdata   = dp_wdata_next;
        end
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        if (dp_act) begin
            e = exp_q[0];
            check_val("resp", 64'(cur_resp), 64'(e.resp));
            if (!cur_rdy) begin
                check_val("rdata_wait", 64'(cur_rdata), 64'd0);
                dp_waits++;
            end else begin
                check_val("waits", 64'(dp_waits), 64'(e.waits));
                if (e.chk_data) begin
                    check_val("rdata", 64'(cur_rdata), 64'(e.rdata));
                end
                void'(exp_q.pop_front());
                dp_act = 1'b0;
            end
        end
        if (cur_rdy && (req_q.size() > 0)) begin
            r      = req_q.pop_front();
            hsel0  = (sel == 0);
            hsel3  = (sel != 0);
            htrans = 2'b10;
            haddr  = r.addr;
            hwrite = r.write;
            hsize  = r.size;
            hburst = 3'b000;
            hprot  = 4'b0011;
            dp_wdata_next = r.wdata;
            push_expected(r);
            addr_drv = 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_q.size() > 0 || addr_drv || dp_act) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_timeout", 64'(req_q.size() > 0 || addr_drv || dp_act), 64'd0);
    endtask

    // Start a WS=3 write to 0x20, then pulse reset while it is still waiting.
    task automatic reset_mid_write();
        @(posedge hclk);
        #1;
        hsel3  = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = 32'h20;
        hsize  = 3'd2;
        @(posedge hclk);
        #1;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwdata = 32'h1234_5678;
        check_val("abort_wait_ready", 64'(rdy3), 64'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b0;
        #1;
        check_val("abort_ready", 64'(rdy3), 64'd1);
        check_val("abort_resp", 64'(resp3), 64'd0);
        check_val("abort_rdata", 64'(rdata3), 64'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        repeat (2) @(posedge hclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b1;
        hsel0   = 1'b0;
        hsel3   = 1'b0;
        haddr   = '0;
        htrans  = 2'b00;
        hwrite  = 1'b0;
        hsize   = 3'd0;
        hburst  = 3'd0;
        hprot   = 4'd0;
        hwdata  = '0;
        #2 hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        check_val("rst_ready0", 64'(rdy0), 64'd1);
        check_val("rst_resp0", 64'(resp0), 64'd0);
        check_val("rst_rdata0", 64'(rdata0), 64'd0);
        check_val("rst_ready3", 64'(rdy3), 64'd1);
        check_val("rst_resp3", 64'(resp3), 64'd0);
        check_val("rst_split0", 64'(split0), 64'd0);
        hresetn = 1'b1;
        repeat (5) begin
            @(posedge hclk);
            #1;
            check_val("idle_ready", 64'(rdy0), 64'd1);
            check_val("idle_resp", 64'(resp0), 64'd0);
            check_val("idle_rdata", 64'(rdata0), 64'd0);
        end

        // Zero wait states: write/read back-to-back, then byte/halfword merges.
        sel = 0;
        queue_xfer(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF);
        queue_xfer(1'b0, 32'h10, 3'd2, 32'h0);
        queue_xfer(1'b1, 32'h10, 3'd2, 32'h1122_3344);
        queue_xfer(1'b1, 32'h13, 3'd0, 32'hAA00_0000);
        queue_xfer(1'b0, 32'h10, 3'd2, 32'h0);
        queue_xfer(1'b1, 32'h14, 3'd2, 32'h0102_0304);
        queue_xfer(1'b1, 32'h16, 3'd1, 32'hBEEF_0000);
        queue_xfer(1'b0, 32'h14, 3'd2, 32'h0);
        drain(60);

        // Illegal accesses: out of range, misaligned halfword write, oversize.
        queue_xfer(1'b1, 32'h0, 3'd2, 32'hCAFE_F00D);
        queue_xfer(1'b0, MB, 3'd2, 32'h0);
        queue_xfer(1'b1, 32'h1, 3'd1, 32'h5A5A_5A5A);
        queue_xfer(1'b1, 32'h8, 3'd3, 32'hFFFF_FFFF);
        queue_xfer(1'b0, 32'h0, 3'd2, 32'h0);
        drain(60);

        // Three wait states.
        sel = 1;
        queue_xfer(1'b1, 32'h20, 3'd2, 32'h5566_7788);
        queue_xfer(1'b0, 32'h20, 3'd2, 32'h0);
        queue_xfer(1'b0, MB + 32'h4, 3'd2, 32'h0);
        drain(60);

        reset_mid_write();
        queue_xfer(1'b0, 32'h20, 3'd2, 32'h0);
        drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
